// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the IF stage: PC register, next-PC selection,
// HALT detection and debug single-step gating, plus a saturating advance counter.
module pc_sequencer #(
  parameter int WIDTH    = 32,
  parameter int INCR     = 1,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_branch,
  input  logic [WIDTH-1:0] i_branch_tgt,
  input  logic             i_jump,
  input  logic [WIDTH-1:0] i_jump_tgt,
  input  logic             i_halt,
  input  logic             i_debug_mode,
  input  logic             i_step,
  input  logic             i_resume,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus,
  output logic             o_enable,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_adv_count
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  // Handshake: o_enable is a qualifier, not a valid/ready pair. The PC only
  // changes at an edge where o_enable is high (or on reset/resume).
  state_t           state;
  logic [WIDTH-1:0] pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             halted_q;
  logic             enable;

  localparam logic [WIDTH-1:0] INCR_W  = WIDTH'(INCR);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_PC);

  assign enable      = (state == RUN) & (~i_debug_mode | i_step);
  assign o_enable    = enable;
  assign o_pc        = pc_q;
  assign o_pc_plus   = pc_q + INCR_W;
  assign o_halted    = halted_q;
  assign o_adv_count = cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= RUN;
      pc_q     <= RESET_W;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (enable) begin
            // Older redirects win; anything younger in the same cycle is wrong-path.
            if (i_branch) begin
              pc_q <= i_branch_tgt;
              if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end else if (i_jump) begin
              pc_q <= i_jump_tgt;
              if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end else if (i_halt) begin
              state    <= HALTED;
              halted_q <= 1'b1;
            end else if (!i_stall) begin
              pc_q <= pc_q + INCR_W;
              if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        HALTED: begin
          if (i_resume) begin
            state    <= RUN;
            halted_q <= 1'b0;
            pc_q     <= RESET_W;
          end
        end
        default: begin
          state    <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default 32-bit instance and a narrow
// WIDTH=8/INCR=4 instance for wrap, counter saturation and reset-while-halted.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---- instance A: defaults ----
  logic        reset, stall, branch, jump, halt, debug_mode, step, resume;
  logic [31:0] branch_tgt, jump_tgt;
  logic [31:0] pc, pc_plus, adv_count;
  logic        enable, halted;

  pc_sequencer dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall),
    .i_branch(branch), .i_branch_tgt(branch_tgt),
    .i_jump(jump), .i_jump_tgt(jump_tgt),
    .i_halt(halt), .i_debug_mode(debug_mode), .i_step(step), .i_resume(resume),
    .o_pc(pc), .o_pc_plus(pc_plus), .o_enable(enable),
    .o_halted(halted), .o_adv_count(adv_count)
  );

  // ---- instance B: narrow, wrapping, small counter ----
  logic       reset_b, jump_b, halt_b, zero_b;
  logic [7:0] jump_tgt_b, zero8_b;
  logic [7:0] pc_b, pc_plus_b;
  logic [2:0] adv_count_b;
  logic       enable_b, halted_b;

  pc_sequencer #(.WIDTH(8), .INCR(4), .RESET_PC(8'h20), .CNT_W(3)) dut_b (
    .i_clk(clk), .i_reset(reset_b), .i_stall(zero_b),
    .i_branch(zero_b), .i_branch_tgt(zero8_b),
    .i_jump(jump_b), .i_jump_tgt(jump_tgt_b),
    .i_halt(halt_b), .i_debug_mode(zero_b), .i_step(zero_b), .i_resume(zero_b),
    .o_pc(pc_b), .o_pc_plus(pc_plus_b), .o_enable(enable_b),
    .o_halted(halted_b), .o_adv_count(adv_count_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch = 1'b0; jump = 1'b0; halt = 1'b0;
    debug_mode = 1'b0; step = 1'b0; resume = 1'b0;
    branch_tgt = '0; jump_tgt = '0;
    reset_b = 1'b1; jump_b = 1'b0; halt_b = 1'b0; zero_b = 1'b0;
    jump_tgt_b = '0; zero8_b = '0;

    // 1. reset then free run
    tick();
    check("rst_pc", pc, 32'd0);
    check("rst_cnt", adv_count, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("run_pc%0d", i), pc, 32'(i));
    end
    check("run_cnt", adv_count, 32'd5);

    // 2. stall at pc=8
    repeat (3) tick();
    check("pre_stall_pc", pc, 32'd8);
    stall = 1'b1;
    tick(); check("stall_pc1", pc, 32'd8);
    tick(); check("stall_pc2", pc, 32'd8);
    stall = 1'b0;
    tick(); check("release_pc", pc, 32'd9);
    check("release_cnt", adv_count, 32'd9);
    check("pc_plus", pc_plus, 32'd10);
    check("enable_run", {31'd0, enable}, 32'd1);

    // 3. branch beats jump, halt and stall
    branch = 1'b1; branch_tgt = 32'h40; jump = 1'b1; jump_tgt = 32'h80;
    stall = 1'b1; halt = 1'b1;
    tick();
    check("branch_pc", pc, 32'h40);
    check("branch_halted", {31'd0, halted}, 32'd0);
    check("branch_cnt", adv_count, 32'd10);
    branch = 1'b0; stall = 1'b0; jump_tgt = 32'h10;
    tick();
    check("jump_pc", pc, 32'h10);
    check("jump_halted", {31'd0, halted}, 32'd0);
    check("jump_cnt", adv_count, 32'd11);
    jump = 1'b0;

    // 4. halt at 0x10, ignore everything for 10 cycles, then resume
    tick();
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_pc", pc, 32'h10);
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step = 1'($urandom_range(0, 1)); jump = 1'($urandom_range(0, 1));
      branch = 1'($urandom_range(0, 1)); debug_mode = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1));
      jump_tgt = $urandom; branch_tgt = $urandom;
      tick();
      check($sformatf("halted_pc%0d", i), pc, 32'h10);
    end
    check("halted_enable", {31'd0, enable}, 32'd0);
    check("halted_cnt", adv_count, 32'd11);
    step = 1'b0; jump = 1'b0; branch = 1'b0; debug_mode = 1'b0; halt = 1'b0;
    resume = 1'b1;
    tick();
    check("resume_pc", pc, 32'd0);
    check("resume_halted", {31'd0, halted}, 32'd0);
    check("resume_cnt", adv_count, 32'd11);
    resume = 1'b0;

    // 5. debug single-step
    debug_mode = 1'b1;
    #1 check("step_idle_enable", {31'd0, enable}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step = 1'b1;
      tick();
      check($sformatf("step_pc%0d", k), pc, 32'(k));
      step = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick();
        check($sformatf("step_hold%0d_%0d", k, j), pc, 32'(k));
      end
    end
    check("step_cnt", adv_count, 32'd14);
    stall = 1'b1; step = 1'b1;
    tick();
    check("step_stall_pc", pc, 32'd3);
    check("step_stall_cnt", adv_count, 32'd14);
    stall = 1'b0; step = 1'b0; debug_mode = 1'b0;

    // 6. narrow instance: wrap, saturation, reset while halted
    reset_b = 1'b0;
    check("b_rst_pc", {24'd0, pc_b}, 32'h20);
    jump_b = 1'b1; jump_tgt_b = 8'hFC;
    tick();
    jump_b = 1'b0;
    check("b_jump_pc", {24'd0, pc_b}, 32'hFC);
    check("b_pc_plus_wrap", {24'd0, pc_plus_b}, 32'h00);
    tick();
    check("b_wrap_pc", {24'd0, pc_b}, 32'h00);
    check("b_wrap_cnt", {29'd0, adv_count_b}, 32'd2);
    repeat (6) tick();
    check("b_run_pc", {24'd0, pc_b}, 32'h18);
    check("b_sat_cnt", {29'd0, adv_count_b}, 32'd7);
    halt_b = 1'b1;
    tick();
    halt_b = 1'b0;
    check("b_halted", {31'd0, halted_b}, 32'd1);
    check("b_halt_pc", {24'd0, pc_b}, 32'h18);
    reset_b = 1'b1;
    tick();
    reset_b = 1'b0;
    check("b_rst2_pc", {24'd0, pc_b}, 32'h20);
    check("b_rst2_halted", {31'd0, halted_b}, 32'd0);
    check("b_rst2_cnt", {29'd0, adv_count_b}, 32'd0);
    tick();
    check("b_run_after_rst", {24'd0, pc_b}, 32'h24);
    check("b_enable", {31'd0, enable_b}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
